// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: next-PC op codes, fetch FSM encodings
// and the fetched-word bundle shared by the fetch slice.
package fetch_ctrl_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JR     = 3'b011;

  localparam logic [1:0] FS_REQ  = 2'd0;
  localparam logic [1:0] FS_WAIT = 2'd1;
  localparam logic [1:0] FS_HOLD = 2'd2;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  function automatic logic npc_op_known(
    input logic [2:0] op
  );
    return (op == NPC_PLUS4) || (op == NPC_BRANCH) ||
           (op == NPC_JUMP)  || (op == NPC_JR);
  endfunction

endpackage

// File: rtl/fetch_ctrl_npc.sv
// npc: word-granular next-PC block (plus4, branch, jump, jr).
// All arithmetic is 30-bit and wraps.
module npc
  import fetch_ctrl_pkg::*;
(
  input  logic [29:0] pc,
  input  logic [2:0]  npc_op,
  input  logic [25:0] imm,
  input  logic [31:0] rs,
  output logic [29:0] npc
);

  logic [29:0] pc_plus1;
  logic [29:0] br_off;
  logic        unused_rs;

  assign pc_plus1  = pc + 30'd1;
  assign br_off    = {{14{imm[15]}}, imm[15:0]};
  assign unused_rs = ^rs[31:30];

  // Select the target; unknown ops leave the PC unchanged.
  always_comb begin
    npc = pc;
    case (npc_op)
      NPC_PLUS4:  npc = pc_plus1;
      NPC_BRANCH: npc = pc_plus1 + br_off;
      NPC_JUMP:   npc = {pc[29:26], imm};
      NPC_JR:     npc = rs[29:0];
      default:    npc = pc;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: one-outstanding instruction fetch sequencer
// with a 1-entry skid buffer and execute redirects.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [2:0]  redirect_op,
  input  logic [29:0] redirect_pc,
  input  logic [25:0] redirect_imm,
  input  logic [31:0] redirect_rs,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [29:0] if_pc,
  output logic [31:0] if_instr
);

  logic [1:0]  state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic        run_q, run_d;
  logic        vld_q, vld_d;
  fetch_word_t slot_q, slot_d;
  fetch_word_t buf_q, buf_d;

  logic [29:0] n_pc;
  logic [2:0]  n_op;
  logic [29:0] n_out;
  logic        req_on;
  logic        slot_free;
  logic        unused_rs_lo;

  assign n_pc = redirect_valid ? redirect_pc : pc_q;
  assign n_op = redirect_valid ? redirect_op : NPC_PLUS4;
  assign unused_rs_lo = ^redirect_rs[1:0];

  npc u_npc (
    .pc     (n_pc),
    .npc_op (n_op),
    .imm    (redirect_imm),
    .rs     ({2'b00, redirect_rs[31:2]}),
    .npc    (n_out)
  );

  // run_q keeps imem_req low until the first edge after reset.
  assign req_on    = run_q && (state_q == FS_REQ);
  assign slot_free = !vld_q || !stall;

  assign imem_req  = req_on;
  assign imem_addr = pc_q;
  assign if_valid  = vld_q;
  assign if_pc     = slot_q.pc;
  assign if_instr  = slot_q.instr;

  // Next-state: redirect first, then the normal fetch walk.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    run_d   = 1'b1;
    vld_d   = vld_q && stall;
    slot_d  = slot_q;
    buf_d   = buf_q;
    if (redirect_valid) begin
      pc_d  = n_out;
      vld_d = 1'b0;
      case (state_q)
        FS_REQ: begin
          if (req_on && imem_gnt) begin
            kill_d  = 1'b1;
            state_d = FS_WAIT;
          end
        end
        FS_WAIT: begin
          // A response landing now is the stale one.
          if (imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = FS_REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end
        default: begin
          kill_d  = 1'b0;
          state_d = FS_REQ;
        end
      endcase
    end else begin
      case (state_q)
        FS_REQ: begin
          if (req_on && imem_gnt) state_d = FS_WAIT;
        end
        FS_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = FS_REQ;
            end else if (slot_free) begin
              slot_d.pc    = pc_q;
              slot_d.instr = imem_rdata;
              vld_d        = 1'b1;
              pc_d         = n_out;
              state_d      = FS_REQ;
            end else begin
              buf_d.pc    = pc_q;
              buf_d.instr = imem_rdata;
              pc_d        = n_out;
              state_d     = FS_HOLD;
            end
          end
        end
        FS_HOLD: begin
          if (slot_free) begin
            slot_d  = buf_q;
            vld_d   = 1'b1;
            state_d = FS_REQ;
          end
        end
        default: state_d = FS_REQ;
      endcase
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FS_REQ;
      pc_q    <= RESET_PC[31:2];
      kill_q  <= 1'b0;
      run_q   <= 1'b0;
      vld_q   <= 1'b0;
      slot_q  <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      run_q   <= run_d;
      vld_q   <= vld_d;
      slot_q  <= slot_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed stimulus with a scoreboard of
// expected request addresses and delivered instructions.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clk;
  logic        rstn;
  logic        stall;
  logic        redirect_valid;
  logic [2:0]  redirect_op;
  logic [29:0] redirect_pc;
  logic [25:0] redirect_imm;
  logic [31:0] redirect_rs;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [29:0] if_pc;
  logic [31:0] if_instr;

  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_op    (redirect_op),
    .redirect_pc    (redirect_pc),
    .redirect_imm   (redirect_imm),
    .redirect_rs    (redirect_rs),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [29:0] req_q[$];
  logic [29:0] exp_q[$];
  int checks;
  int failures;
  int grant_limit;
  int grants_done;
  int lat;
  int tmo_raised;
  int tmo_seen;
  logic chk_noreq;
  logic done;
  logic mon_done;

  assign imem_gnt = (grants_done < grant_limit);

  function automatic logic [31:0] wfn(input logic [29:0] pc);
    return {pc, 2'b01} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory model: one outstanding request, fixed latency.
  logic        hs_pred;
  logic [29:0] hs_addr;
  logic        mem_pend;
  logic [29:0] mem_addr;
  int          mem_cnt;
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    hs_pred     = 1'b0;
    hs_addr     = '0;
    mem_pend    = 1'b0;
    mem_addr    = '0;
    mem_cnt     = 0;
    grants_done = 0;
    forever begin
      @(negedge clk);
      #2;
      if (imem_rvalid) imem_rvalid = 1'b0;
      if (hs_pred) begin
        mem_pend = 1'b1;
        mem_addr = hs_addr;
        mem_cnt  = lat;
        grants_done++;
      end
      if (mem_pend) begin
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = wfn(mem_addr);
          mem_pend    = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      hs_pred = imem_req && imem_gnt;
      hs_addr = imem_addr;
    end
  end

  // Monitor: compares every request and delivery to the queues.
  logic        prev_redir;
  logic        prev_hold;
  logic [29:0] prev_pc;
  logic [31:0] prev_instr;
  logic [29:0] p;
  initial begin
    checks     = 0;
    failures   = 0;
    tmo_seen   = 0;
    mon_done   = 1'b0;
    prev_redir = 1'b0;
    prev_hold  = 1'b0;
    prev_pc    = '0;
    prev_instr = '0;
    forever begin
      @(negedge clk);
      #3;
      if (tmo_raised != tmo_seen) begin
        checks++;
        failures++;
        $display("FAIL drain_timeout: got %0d expected %0d",
                 tmo_raised, tmo_seen);
        tmo_seen = tmo_raised;
      end
      if (!rstn) begin
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_pc", {2'b0, if_pc}, 32'd0);
        chk("rst_if_instr", if_instr, 32'd0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
        prev_redir = 1'b0;
        prev_hold  = 1'b0;
      end else begin
        if (prev_redir) begin
          chk("flush", {31'b0, if_valid}, 32'd0);
        end else if (prev_hold) begin
          chk("hold_valid", {31'b0, if_valid}, 32'd1);
          chk("hold_pc", {2'b0, if_pc}, {2'b0, prev_pc});
          chk("hold_instr", if_instr, prev_instr);
        end
        if (imem_req && imem_gnt) begin
          if (req_q.size() == 0) begin
            chk("unexpected_req", {2'b0, imem_addr}, 32'hFFFF_FFFF);
          end else begin
            p = req_q.pop_front();
            chk("req_addr", {2'b0, imem_addr}, {2'b0, p});
          end
        end
        if (chk_noreq) chk("hold_noreq", {31'b0, imem_req}, 32'd0);
        if (if_valid && !stall && !redirect_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_if", {2'b0, if_pc}, 32'hFFFF_FFFF);
          end else begin
            p = exp_q.pop_front();
            chk("if_pc", {2'b0, if_pc}, {2'b0, p});
            chk("if_instr", if_instr, wfn(p));
          end
        end
        if (redirect_valid && !npc_op_known(redirect_op))
          $display("note: redirect_op %0d is not an NPC op",
                   redirect_op);
        prev_redir = redirect_valid;
        prev_hold  = if_valid && stall && !redirect_valid;
        prev_pc    = if_pc;
        prev_instr = if_instr;
      end
      if (done && !mon_done) begin
        chk("req_q_left", req_q.size(), 32'd0);
        chk("exp_q_left", exp_q.size(), 32'd0);
        mon_done = 1'b1;
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while ((req_q.size() != 0 || exp_q.size() != 0) && n < 300) begin
      cyc();
      n++;
    end
    if (n >= 300) tmo_raised++;
    cyc();
    cyc();
  endtask

  task automatic wait_grant();
    int g0;
    int n;
    g0 = grants_done;
    n  = 0;
    while (grants_done == g0 && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) tmo_raised++;
  endtask

  task automatic wait_ifv();
    int n;
    n = 0;
    while (!if_valid && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) tmo_raised++;
  endtask

  task automatic do_redir(input logic [2:0] op,
                          input logic [29:0] rpc,
                          input logic [25:0] im,
                          input logic [31:0] rs);
    redirect_valid = 1'b1;
    redirect_op    = op;
    redirect_pc    = rpc;
    redirect_imm   = im;
    redirect_rs    = rs;
    cyc();
    redirect_valid = 1'b0;
  endtask

  // Directed phases; each pushes what the DUT must show next.
  initial begin
    rstn           = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_op    = NPC_PLUS4;
    redirect_pc    = '0;
    redirect_imm   = '0;
    redirect_rs    = '0;
    grant_limit    = 0;
    lat            = 0;
    tmo_raised     = 0;
    chk_noreq      = 1'b0;
    done           = 1'b0;
    repeat (3) cyc();
    rstn = 1'b1;
    cyc();
    cyc();

    lat = 1;
    for (int i = 0; i < 4; i++) begin
      req_q.push_back(30'h0C00 + 30'(i));
      exp_q.push_back(30'h0C00 + 30'(i));
    end
    grant_limit += 4;
    drain();

    lat   = 0;
    stall = 1'b1;
    for (int i = 4; i < 7; i++) begin
      req_q.push_back(30'h0C00 + 30'(i));
      exp_q.push_back(30'h0C00 + 30'(i));
    end
    grant_limit += 3;
    repeat (6) cyc();
    chk_noreq = 1'b1;
    repeat (3) cyc();
    chk_noreq = 1'b0;
    stall     = 1'b0;
    drain();

    lat = 3;
    req_q.push_back(30'h0C07);
    grant_limit += 1;
    wait_grant();
    do_redir(NPC_BRANCH, 30'h0C05, 26'h000FFFD, 32'h0);
    req_q.push_back(30'h0C03);
    exp_q.push_back(30'h0C03);
    grant_limit += 1;
    drain();

    lat   = 0;
    stall = 1'b1;
    req_q.push_back(30'h0C04);
    grant_limit += 1;
    wait_ifv();
    do_redir(NPC_JUMP, 30'h0C05, 26'h0000C10, 32'h0);
    stall = 1'b0;
    req_q.push_back(30'h0C10);
    exp_q.push_back(30'h0C10);
    grant_limit += 1;
    drain();

    do_redir(NPC_JR, 30'h0C11, 26'h0, 32'h0000_3080);
    req_q.push_back(30'h0C20);
    exp_q.push_back(30'h0C20);
    grant_limit += 1;
    drain();

    do_redir(NPC_JR, 30'h0C21, 26'h0, 32'hFFFF_FFFC);
    req_q.push_back(30'h3FFF_FFFF);
    req_q.push_back(30'h0);
    exp_q.push_back(30'h3FFF_FFFF);
    exp_q.push_back(30'h0);
    grant_limit += 2;
    drain();

    lat = 1;
    req_q.push_back(30'h1);
    req_q.push_back(30'h0C08);
    exp_q.push_back(30'h0C08);
    grant_limit += 2;
    do_redir(NPC_BRANCH, 30'h0C05, 26'h0000002, 32'h0);
    drain();

    lat   = 0;
    stall = 1'b1;
    req_q.push_back(30'h0C09);
    grant_limit += 1;
    wait_ifv();
    lat = 3;
    req_q.push_back(30'h0C0A);
    grant_limit += 1;
    wait_grant();
    rstn = 1'b0;
    cyc();
    rstn  = 1'b1;
    stall = 1'b0;
    repeat (8) cyc();
    req_q.push_back(30'h0C00);
    exp_q.push_back(30'h0C00);
    grant_limit += 1;
    drain();

    done = 1'b1;
    repeat (4) cyc();
    if (!mon_done) begin
      $display("FAIL monitor_end: got 0 expected 1");
      $fatal(1, "monitor did not finish");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
